// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter. The in-order Write stage owns the port
// by default. Results from the long-latency unit wait in a small FIFO and
// drain on idle cycles. A starvation counter forces a one-cycle stall so
// queued results always make progress.
module wb_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_regwr,
  input  logic [4:0]  wb_rw,
  input  logic [31:0] wb_busW,
  input  logic [1:0]  wb_fpoint,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rw,
  input  logic [31:0] lu_data,
  input  logic [1:0]  lu_fpoint,
  output logic        lu_ready,
  output logic        regwr,
  output logic [4:0]  rw,
  output logic [31:0] busW,
  output logic [1:0]  fpoint,
  output logic        stall_req
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic        vld;
    logic [4:0]  rw;
    logic [31:0] data;
    logic [1:0]  fpoint;
  } ent_t;

  ent_t            ent_q [DEPTH];
  logic [AW-1:0]   head_q, tail_q;
  logic [AW:0]     count_q;
  logic [SW-1:0]   starve_q;
  logic [DEPTH-1:0] squash;

  logic wbreq, nonempty, has_room, starved, head_gnt, wb_gnt, push;
  ent_t head_ent;

  // Integer r0 writes are not real writes and never claim the port.
  assign wbreq    = wb_regwr && !(wb_fpoint == 2'b00 && wb_rw == 5'd0);
  assign nonempty = (count_q != '0);
  assign has_room = (count_q < DEPTH_C);
  assign starved  = (starve_q == LIMIT_C) && nonempty;
  assign head_gnt = !reset && nonempty && (starved || !wbreq);
  assign wb_gnt   = !reset && wbreq && !starved;
  // Accept is based on registered occupancy only; a full buffer never
  // takes a result even if the head pops this cycle.
  assign push     = lu_valid && has_room;
  assign head_ent = ent_q[head_q];

  assign lu_ready  = reset || has_room;
  assign stall_req = !reset && starved;

  // Per-entry WAW squash: an older queued result to the same register is
  // superseded by the Write stage's in-order write.
  for (genvar i = 0; i < DEPTH; i++) begin : g_sq
    assign squash[i] = wb_gnt && ent_q[i].vld &&
                       (ent_q[i].rw == wb_rw) && (ent_q[i].fpoint == wb_fpoint);
  end

  // Port mux: buffer head when granted, else Write stage, else idle zeros.
  always_comb begin
    regwr  = 1'b0;
    rw     = 5'd0;
    busW   = 32'd0;
    fpoint = 2'b00;
    if (head_gnt) begin
      regwr  = head_ent.vld;
      rw     = head_ent.rw;
      busW   = head_ent.data;
      fpoint = head_ent.fpoint;
    end else if (wb_gnt) begin
      regwr  = 1'b1;
      rw     = wb_rw;
      busW   = wb_busW;
      fpoint = wb_fpoint;
    end
  end

  // Entry storage: push fills the free tail slot (never squashed, it is
  // younger), pop and squash clear valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].vld <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && tail_q == AW'(i)) begin
          ent_q[i].vld    <= !(lu_fpoint == 2'b00 && lu_rw == 5'd0);
          ent_q[i].rw     <= lu_rw;
          ent_q[i].data   <= lu_data;
          ent_q[i].fpoint <= lu_fpoint;
        end else if ((head_gnt && head_q == AW'(i)) || squash[i]) begin
          ent_q[i].vld <= 1'b0;
        end
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)     tail_q <= tail_q + 1'b1;
      if (head_gnt) head_q <= head_q + 1'b1;
      case ({push, head_gnt})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Starvation counter: counts blocked cycles while work is queued,
  // saturating; any head grant or an empty buffer clears it.
  always_ff @(posedge clk) begin
    if (reset || !nonempty || head_gnt) starve_q <= '0;
    else if (starve_q != LIMIT_C)       starve_q <= starve_q + 1'b1;
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed vector table, a starvation sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_wb_write_arbiter;
  localparam int DEPTH = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_regwr = 1'b0;
  logic [4:0]  wb_rw = '0;
  logic [31:0] wb_busW = '0;
  logic [1:0]  wb_fpoint = '0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_rw = '0;
  logic [31:0] lu_data = '0;
  logic [1:0]  lu_fpoint = '0;
  logic        lu_ready, regwr, stall_req;
  logic [4:0]  rw;
  logic [31:0] busW;
  logic [1:0]  fpoint;

  int n_chk = 0;
  int n_fail = 0;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_regwr(wb_regwr), .wb_rw(wb_rw), .wb_busW(wb_busW), .wb_fpoint(wb_fpoint),
    .lu_valid(lu_valid), .lu_rw(lu_rw), .lu_data(lu_data), .lu_fpoint(lu_fpoint),
    .lu_ready(lu_ready), .regwr(regwr), .rw(rw), .busW(busW), .fpoint(fpoint),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [4:0]  wrw;
    logic [31:0] wd;
    logic [1:0]  wfp;
    logic        lv;
    logic [4:0]  lrw;
    logic [31:0] ld;
    logic [1:0]  lfp;
    logic        e_wr;
    logic [4:0]  e_rw;
    logic [31:0] e_d;
    logic [1:0]  e_fp;
    logic        e_rdy;
    logic        e_st;
  } vec_t;

  function automatic vec_t mk(logic rst, logic wr, logic [4:0] wrw, logic [31:0] wd,
                              logic [1:0] wfp, logic lv, logic [4:0] lrw, logic [31:0] ld,
                              logic [1:0] lfp, logic e_wr, logic [4:0] e_rw, logic [31:0] e_d,
                              logic [1:0] e_fp, logic e_rdy, logic e_st);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wrw = wrw; v.wd = wd; v.wfp = wfp;
    v.lv = lv; v.lrw = lrw; v.ld = ld; v.lfp = lfp;
    v.e_wr = e_wr; v.e_rw = e_rw; v.e_d = e_d; v.e_fp = e_fp;
    v.e_rdy = e_rdy; v.e_st = e_st;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic ewr, input logic [4:0] erw,
                           input logic [31:0] ed, input logic [1:0] efp,
                           input logic erdy, input logic est);
    cmp({tag, ".regwr"},     32'(regwr),     32'(ewr));
    cmp({tag, ".rw"},        32'(rw),        32'(erw));
    cmp({tag, ".busW"},      busW,           ed);
    cmp({tag, ".fpoint"},    32'(fpoint),    32'(efp));
    cmp({tag, ".lu_ready"},  32'(lu_ready),  32'(erdy));
    cmp({tag, ".stall_req"}, 32'(stall_req), 32'(est));
  endtask

  task automatic drive(input logic rst, input logic wr, input logic [4:0] wrw,
                       input logic [31:0] wd, input logic [1:0] wfp, input logic lv,
                       input logic [4:0] lrw, input logic [31:0] ld, input logic [1:0] lfp);
    reset = rst; wb_regwr = wr; wb_rw = wrw; wb_busW = wd; wb_fpoint = wfp;
    lu_valid = lv; lu_rw = lrw; lu_data = ld; lu_fpoint = lfp;
  endtask

  // Reference model: a queue of pending results in arrival order plus a
  // count of consecutive cycles the oldest one has been kept waiting.
  typedef struct {
    logic        v;
    logic [4:0]  rw;
    logic [31:0] d;
    logic [1:0]  fp;
  } ment_t;

  ment_t mq[$];
  int    m_wait = 0;

  function automatic bit m_req();
    return wb_regwr && !(wb_fpoint == 2'b00 && wb_rw == 5'd0);
  endfunction

  function automatic bit m_forced();
    return (m_wait >= STARVE_LIMIT) && (mq.size() > 0);
  endfunction

  task automatic model_expect(output logic ewr, output logic [4:0] erw,
                              output logic [31:0] ed, output logic [1:0] efp,
                              output logic erdy, output logic est);
    bit drain;
    ewr = 0; erw = 0; ed = 0; efp = 0; erdy = 1; est = 0;
    if (!reset) begin
      est   = m_forced();
      erdy  = (mq.size() < DEPTH);
      drain = (mq.size() > 0) && (est || !m_req());
      if (drain) begin
        ewr = mq[0].v; erw = mq[0].rw; ed = mq[0].d; efp = mq[0].fp;
      end else if (m_req()) begin
        ewr = 1; erw = wb_rw; ed = wb_busW; efp = wb_fpoint;
      end
    end
  endtask

  task automatic model_commit();
    bit drain, forced, take;
    ment_t e;
    if (reset) begin
      mq.delete();
      m_wait = 0;
      return;
    end
    forced = m_forced();
    drain  = (mq.size() > 0) && (forced || !m_req());
    take   = lu_valid && (mq.size() < DEPTH);
    if (m_req() && !forced)
      foreach (mq[i]) if (mq[i].rw == wb_rw && mq[i].fp == wb_fpoint) mq[i].v = 0;
    if (mq.size() == 0 || drain) m_wait = 0;
    else if (m_wait < STARVE_LIMIT) m_wait++;
    if (drain) void'(mq.pop_front());
    if (take) begin
      e.v = !(lu_fpoint == 2'b00 && lu_rw == 5'd0);
      e.rw = lu_rw; e.d = lu_data; e.fp = lu_fpoint;
      mq.push_back(e);
    end
  endtask

  vec_t tbl[28];

  initial begin
    logic        ewr, erdy, est;
    logic [4:0]  erw;
    logic [31:0] ed;
    logic [1:0]  efp;
    logic        hold;

    //          rst wr wrw wd        wfp lv lrw ld           lfp  ewr erw ed           efp rdy st
    tbl[0]  = mk(1, 0, 0,  0,        0,  0, 0,  0,           0,   0,  0,  0,           0,  1,  0);
    tbl[1]  = mk(0, 0, 0,  0,        0,  1, 5,  32'hDEADBEEF,0,   0,  0,  0,           0,  1,  0);
    tbl[2]  = mk(0, 0, 0,  0,        0,  0, 0,  0,           0,   1,  5,  32'hDEADBEEF,0,  1,  0);
    tbl[3]  = mk(0, 0, 0,  0,        0,  0, 0,  0,           0,   0,  0,  0,           0,  1,  0);
    tbl[4]  = mk(0, 1, 1,  32'h100,  0,  1, 3,  32'h33,      0,   1,  1,  32'h100,     0,  1,  0);
    tbl[5]  = mk(0, 1, 0,  32'h999,  0,  0, 0,  0,           0,   1,  3,  32'h33,      0,  1,  0);
    tbl[6]  = mk(0, 1, 0,  32'h55,   1,  0, 0,  0,           0,   1,  0,  32'h55,      1,  1,  0);
    tbl[7]  = mk(0, 1, 2,  32'h200,  0,  1, 10, 32'hA,       0,   1,  2,  32'h200,     0,  1,  0);
    tbl[8]  = mk(0, 1, 4,  32'h400,  0,  1, 11, 32'hB,       0,   1,  4,  32'h400,     0,  1,  0);
    tbl[9]  = mk(1, 0, 0,  0,        0,  0, 0,  0,           0,   0,  0,  0,           0,  1,  0);
    tbl[10] = mk(0, 0, 0,  0,        0,  0, 0,  0,           0,   0,  0,  0,           0,  1,  0);
    tbl[11] = mk(0, 1, 1,  32'h1,    0,  1, 7,  32'h11,      0,   1,  1,  32'h1,       0,  1,  0);
    tbl[12] = mk(0, 1, 7,  32'h22,   0,  0, 0,  0,           0,   1,  7,  32'h22,      0,  1,  0);
    tbl[13] = mk(0, 0, 0,  0,        0,  0, 0,  0,           0,   0,  7,  32'h11,      0,  1,  0);
    tbl[14] = mk(0, 0, 0,  0,        0,  0, 0,  0,           0,   0,  0,  0,           0,  1,  0);
    tbl[15] = mk(0, 1, 7,  32'h33,   0,  1, 7,  32'h44,      0,   1,  7,  32'h33,      0,  1,  0);
    tbl[16] = mk(0, 0, 0,  0,        0,  0, 0,  0,           0,   1,  7,  32'h44,      0,  1,  0);
    tbl[17] = mk(0, 0, 0,  0,        0,  0, 0,  0,           0,   0,  0,  0,           0,  1,  0);
    tbl[18] = mk(0, 1, 1,  32'h1,    0,  1, 20, 32'hA0,      2,   1,  1,  32'h1,       0,  1,  0);
    tbl[19] = mk(0, 1, 2,  32'h2,    0,  1, 21, 32'hA1,      1,   1,  2,  32'h2,       0,  1,  0);
    tbl[20] = mk(0, 1, 3,  32'h3,    0,  1, 22, 32'hA2,      0,   1,  3,  32'h3,       0,  0,  0);
    tbl[21] = mk(0, 0, 0,  0,        0,  1, 22, 32'hA2,      0,   1,  20, 32'hA0,      2,  0,  0);
    tbl[22] = mk(0, 0, 0,  0,        0,  1, 22, 32'hA2,      0,   1,  21, 32'hA1,      1,  1,  0);
    tbl[23] = mk(0, 0, 0,  0,        0,  0, 0,  0,           0,   1,  22, 32'hA2,      0,  1,  0);
    tbl[24] = mk(0, 0, 0,  0,        0,  0, 0,  0,           0,   0,  0,  0,           0,  1,  0);
    tbl[25] = mk(0, 0, 0,  0,        0,  1, 0,  32'h77,      0,   0,  0,  0,           0,  1,  0);
    tbl[26] = mk(0, 0, 0,  0,        0,  0, 0,  0,           0,   0,  0,  32'h77,      0,  1,  0);
    tbl[27] = mk(0, 0, 0,  0,        0,  0, 0,  0,           0,   0,  0,  0,           0,  1,  0);

    @(posedge clk); #1;

    // Directed vectors: one row per clock, outputs sampled mid-cycle.
    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].rst, tbl[i].wr, tbl[i].wrw, tbl[i].wd, tbl[i].wfp,
            tbl[i].lv, tbl[i].lrw, tbl[i].ld, tbl[i].lfp);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), tbl[i].e_wr, tbl[i].e_rw, tbl[i].e_d,
                tbl[i].e_fp, tbl[i].e_rdy, tbl[i].e_st);
      @(posedge clk); #1;
    end

    // Starvation: r9 queued under continuous Write-stage traffic. Four
    // blocked cycles, then one forced drain while r6 is held, r6 follows.
    for (int c = 0; c < 9; c++) begin
      logic [4:0] r;
      r = (c < 6) ? 5'(c + 1) : 5'(c);
      drive(0, 1, r, 32'h1000 + 32'(r), 2'b00, (c == 0), 5'd9, 32'h99, 2'b00);
      @(negedge clk);
      if (c == 5) check_all($sformatf("starve%0d", c), 1, 9, 32'h99, 0, 1, 1);
      else        check_all($sformatf("starve%0d", c), 1, r, 32'h1000 + 32'(r), 0, 1, 0);
      @(posedge clk); #1;
    end

    // Randomized traffic against the reference model. Small register and
    // select ranges make WAW hits common; busy Write stage forces stalls.
    hold = 0;
    for (int n = 0; n < 400; n++) begin
      logic rs;
      rs = (n == 0) || ($urandom_range(0, 59) == 0);
      reset = rs;
      wb_regwr  = ($urandom_range(0, 9) < 8);
      wb_rw     = 5'($urandom_range(0, 3));
      wb_fpoint = 2'($urandom_range(0, 1));
      wb_busW   = $urandom;
      if (!hold) begin
        lu_valid  = ($urandom_range(0, 2) == 0);
        lu_rw     = 5'($urandom_range(0, 3));
        lu_fpoint = 2'($urandom_range(0, 1));
        lu_data   = $urandom;
      end
      model_expect(ewr, erw, ed, efp, erdy, est);
      @(negedge clk);
      check_all($sformatf("rnd%0d", n), ewr, erw, ed, efp, erdy, est);
      hold = lu_valid && !erdy && !rs;
      model_commit();
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
